// File: rtl/dm_arbiter_if.sv
// Bundle of the two requester ports and the data_memory port seen by dm_arbiter.
// slave is the arbiter's view; master is the requesters plus the memory.
interface dm_arbiter_if;
    logic       req_a;
    logic       req_b;
    logic       we_a;
    logic       we_b;
    logic [3:0] addr_a;
    logic [3:0] addr_b;
    logic [3:0] wdata_a;
    logic [3:0] wdata_b;
    logic       gnt_a;
    logic       gnt_b;
    logic       rvalid_a;
    logic       rvalid_b;
    logic [3:0] rdata;
    logic [3:0] mem_address;
    logic [3:0] mem_data;
    logic       mem_wren;
    logic [3:0] mem_q;
    logic       busy;

    modport slave (
        input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, mem_q,
        output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata, mem_address, mem_data,
               mem_wren, busy
    );

    modport master (
        output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, mem_q,
        input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata, mem_address, mem_data,
               mem_wren, busy
    );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing the 16x4 data memory between the computational
// unit (port A) and the host/debug loader (port B), with a bounded hold time.
module dm_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic        clk,
    input  logic        reset,
    dm_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     state_r, state_nx_s;
    logic       last_b_r, last_b_nx_s;
    logic [3:0] hold_r, hold_nx_s;
    logic       access_a_s, access_b_s;
    logic       gnt_a_r, gnt_b_r, busy_r;
    logic       rvalid_a_r, rvalid_b_r;
    logic [3:0] mem_address_s, mem_data_s;
    logic       mem_wren_s;

    assign access_a_s = (state_r == OWN_A) && bus.req_a;
    assign access_b_s = (state_r == OWN_B) && bus.req_b;

    // Next-state: every handoff passes through IDLE so the bus never changes owner back-to-back
    always_comb begin
        state_nx_s  = state_r;
        last_b_nx_s = last_b_r;
        hold_nx_s   = hold_r;
        case (state_r)
            IDLE: begin
                if (bus.req_a && (!bus.req_b || last_b_r)) begin
                    state_nx_s  = OWN_A;
                    last_b_nx_s = 1'b0;
                    hold_nx_s   = 4'd0;
                end else if (bus.req_b) begin
                    state_nx_s  = OWN_B;
                    last_b_nx_s = 1'b1;
                    hold_nx_s   = 4'd0;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            OWN_A: begin
                if (!bus.req_a) begin
                    state_nx_s = IDLE;
                end else if (hold_r == HOLD_LAST) begin
                    if (bus.req_b) begin
                        state_nx_s = IDLE;
                    end else begin
                        hold_nx_s = hold_r;
                    end
                end else begin
                    hold_nx_s = hold_r + 4'd1;
                end
            end
            OWN_B: begin
                if (!bus.req_b) begin
                    state_nx_s = IDLE;
                end else if (hold_r == HOLD_LAST) begin
                    if (bus.req_a) begin
                        state_nx_s = IDLE;
                    end else begin
                        hold_nx_s = hold_r;
                    end
                end else begin
                    hold_nx_s = hold_r + 4'd1;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Arbitration state, grants and read-valid pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            last_b_r   <= 1'b1;
            hold_r     <= 4'd0;
            gnt_a_r    <= 1'b0;
            gnt_b_r    <= 1'b0;
            busy_r     <= 1'b0;
            rvalid_a_r <= 1'b0;
            rvalid_b_r <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            last_b_r   <= last_b_nx_s;
            hold_r     <= hold_nx_s;
            gnt_a_r    <= (state_nx_s == OWN_A);
            gnt_b_r    <= (state_nx_s == OWN_B);
            busy_r     <= (state_nx_s != IDLE);
            rvalid_a_r <= access_a_s && !bus.we_a;
            rvalid_b_r <= access_b_s && !bus.we_b;
        end
    end

    // Memory steering: only a live access cycle may drive the memory port
    always_comb begin
        mem_address_s = 4'd0;
        mem_data_s    = 4'd0;
        mem_wren_s    = 1'b0;
        if (access_a_s) begin
            mem_address_s = bus.addr_a;
            mem_data_s    = bus.wdata_a;
            mem_wren_s    = bus.we_a;
        end else if (access_b_s) begin
            mem_address_s = bus.addr_b;
            mem_data_s    = bus.wdata_b;
            mem_wren_s    = bus.we_b;
        end else begin
            mem_address_s = 4'd0;
            mem_data_s    = 4'd0;
            mem_wren_s    = 1'b0;
        end
    end

    assign bus.gnt_a       = gnt_a_r;
    assign bus.gnt_b       = gnt_b_r;
    assign bus.busy        = busy_r;
    assign bus.rvalid_a    = rvalid_a_r;
    assign bus.rvalid_b    = rvalid_b_r;
    assign bus.rdata       = bus.mem_q;
    assign bus.mem_address = mem_address_s;
    assign bus.mem_data    = mem_data_s;
    assign bus.mem_wren    = mem_wren_s;
endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a negedge-clocked 16x4 memory model and a
// scoreboard of expected post-edge outputs.
module tb_dm_arbiter;
    logic clk;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;

    dm_arbiter_if bus ();

    dm_arbiter #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string      tag;
        logic       ga;
        logic       gb;
        logic       rva;
        logic       rvb;
        logic       chk_rd;
        logic [3:0] rd;
    } exp_t;

    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: contents preloaded with ~address, clocked on the falling edge
    logic [3:0] mem [16];
    logic       loaded = 1'b0;
    always @(negedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 16; i++) mem[i] <= ~4'(i);
            loaded <= 1'b1;
        end else begin
            if (bus.mem_wren) mem[bus.mem_address] <= bus.mem_data;
            bus.mem_q <= mem[bus.mem_address];
        end
    end

    // Grants must be mutually exclusive at all times
    always @(negedge clk) begin
        compared++;
        assert (!(bus.gnt_a && bus.gnt_b)) else begin
            mismatched++;
            $error("FAIL both_grants observed=%b%b expected=not both", bus.gnt_a, bus.gnt_b);
        end
    end

    task automatic cmp1(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cmp4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mem_chk(input string tag, input logic wren, input logic [3:0] addr,
                           input logic [3:0] data);
        cmp1({tag, "_wren"}, bus.mem_wren, wren);
        cmp4({tag, "_addr"}, bus.mem_address, addr);
        cmp4({tag, "_data"}, bus.mem_data, data);
    endtask

    task automatic drive(input string tag, input logic ra, input logic rb,
                         input logic wa, input logic wb,
                         input logic [3:0] aa, input logic [3:0] ab,
                         input logic [3:0] da, input logic [3:0] db,
                         input logic ega, input logic egb,
                         input logic erva, input logic ervb,
                         input logic chk, input logic [3:0] erd);
        exp_t e;
        bus.req_a   = ra;
        bus.req_b   = rb;
        bus.we_a    = wa;
        bus.we_b    = wb;
        bus.addr_a  = aa;
        bus.addr_b  = ab;
        bus.wdata_a = da;
        bus.wdata_b = db;
        e.tag = tag; e.ga = ega; e.gb = egb; e.rva = erva; e.rvb = ervb;
        e.chk_rd = chk; e.rd = erd;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        compared++;
        assert (sb.size() != 0) else begin
            mismatched++;
            $error("FAIL sb_empty observed=0 entries expected=1 entry");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            cmp1({e.tag, "_gnt_a"}, bus.gnt_a, e.ga);
            cmp1({e.tag, "_gnt_b"}, bus.gnt_b, e.gb);
            cmp1({e.tag, "_busy"}, bus.busy, e.ga | e.gb);
            cmp1({e.tag, "_rvalid_a"}, bus.rvalid_a, e.rva);
            cmp1({e.tag, "_rvalid_b"}, bus.rvalid_b, e.rvb);
            if (e.chk_rd) cmp4({e.tag, "_rdata"}, bus.rdata, e.rd);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive("init", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        void'(sb.pop_front());
        repeat (2) @(posedge clk);
        #1;
        cmp1("rst_gnt_a", bus.gnt_a, 1'b0);
        cmp1("rst_gnt_b", bus.gnt_b, 1'b0);
        cmp1("rst_busy", bus.busy, 1'b0);
        cmp1("rst_rvalid_a", bus.rvalid_a, 1'b0);
        cmp1("rst_rvalid_b", bus.rvalid_b, 1'b0);
        cmp1("rst_wren", bus.mem_wren, 1'b0);
        reset = 1'b0;

        // Single port: grant, write 9 to addr 3, read it back
        drive("sp_req", 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0,
              1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        tick();
        drive("sp_wr", 1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 4'h0, 4'h9, 4'h0,
              1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        #1 mem_chk("sp_wr", 1'b1, 4'h3, 4'h9);
        tick();
        drive("sp_rd", 1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 4'h0, 4'h0, 4'h0,
              1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h9);
        tick();
        drive("sp_rel", 1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 4'h0, 4'h0, 4'h0,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        tick();

        // Asynchronous reset in the middle of a read access
        drive("rs_req", 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0,
              1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        tick();
        drive("rs_rd", 1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 4'h0, 4'h0, 4'h0,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        #2 reset = 1'b1;
        #1;
        cmp1("rs_async_gnt_a", bus.gnt_a, 1'b0);
        cmp1("rs_async_busy", bus.busy, 1'b0);
        cmp1("rs_async_rvalid_a", bus.rvalid_a, 1'b0);
        cmp1("rs_async_wren", bus.mem_wren, 1'b0);
        tick();
        reset = 1'b0;

        // Tie after reset: A first, then one idle cycle, then B
        drive("tie_req", 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0,
              1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        tick();
        drive("tie_a", 1'b1, 1'b1, 1'b1, 1'b0, 4'h2, 4'h0, 4'h4, 4'h0,
              1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        #1 mem_chk("tie_a", 1'b1, 4'h2, 4'h4);
        tick();
        drive("tie_drop", 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        tick();
        drive("tie_turn", 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0,
              1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        tick();

        // Continuous contention starting with B owning; B's 4th access in the
        // last round is a read of addr 5 (preloaded ~5 = A)
        for (int i = 0; i < 24; i++) begin
            int   j;
            logic idle;
            logic own_b;
            j     = i + 1;
            idle  = ((j % 5) == 4);
            own_b = (((j / 5) % 2) == 0);
            drive($sformatf("cont%0d", i), 1'b1, 1'b1, 1'b1, (i != 23),
                  4'h0, (i == 23) ? 4'h5 : 4'h1, 4'(i), 4'(i + 1),
                  !idle && !own_b, !idle && own_b, 1'b0, (i == 23),
                  (i == 23), 4'hA);
            tick();
        end
        drive("iso_after", 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'h1, 4'h0, 4'h0,
              1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        tick();

        // Early release by B while A waits
        drive("er_a_drop", 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        tick();
        drive("er_b_req", 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0,
              1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        tick();
        drive("er_b1", 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'h6, 4'h0, 4'h3,
              1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        tick();
        drive("er_b2", 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'h6, 4'h0, 4'h3,
              1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        tick();
        drive("er_drop", 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h7, 4'h0, 4'hF,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        #1 mem_chk("er_drop", 1'b0, 4'h0, 4'h0);
        tick();
        drive("er_turn", 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0,
              1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        tick();
        drive("er_a_rd6", 1'b1, 1'b0, 1'b0, 1'b0, 4'h6, 4'h0, 4'h0, 4'h0,
              1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h3);
        tick();
        drive("er_a_rd7", 1'b1, 1'b0, 1'b0, 1'b0, 4'h7, 4'h0, 4'h0, 4'h0,
              1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h8);
        tick();
        drive("er_end", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
